// File: rtl/bpu_update_gen.sv
// BPU update/redirect generator: checks resolved control flow against the predicted npc and
// issues a one-cycle redirect on mispredict or exception, with epoch tracking and drain.
module bpu_update_gen #(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             resolve_valid_i,
    input  logic             resolve_is_cf_i,
    input  logic [31:0]      resolve_pc_i,
    input  logic             resolve_taken_i,
    input  logic [31:0]      resolve_target_i,
    input  logic [31:0]      resolve_pred_npc_i,
    input  logic             resolve_epoch_i,
    input  logic             excp_valid_i,
    input  logic [31:0]      excp_target_i,
    output logic             epoch_o,
    output logic             update_taken_o,
    output logic [31:0]      update_target_o,
    output logic             flush_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    typedef enum logic [1:0] {
        StIdle,
        StRedirect,
        StDrain
    } state_e;

    localparam logic [3:0] DrainLoad = 4'(DRAIN_CYCLES);

    state_e           state_q;
    logic [3:0]       drain_cnt_q;
    logic             epoch_q;
    logic             update_taken_q;
    logic             flush_q;
    logic [31:0]      update_target_q;
    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] mispred_cnt_q;

    logic [31:0] seq_npc;
    logic [31:0] exp_npc;
    logic        accept;
    logic        mispredict;
    logic        redirect_req;
    logic [31:0] redirect_tgt;

    // Offset within the fetch group never affects the sequential npc.
    logic unused_pc_lo;
    assign unused_pc_lo = ^resolve_pc_i[2:0];

    always_comb begin
        seq_npc      = {resolve_pc_i[31:3] + 29'd1, 3'b000};
        exp_npc      = resolve_taken_i ? resolve_target_i : seq_npc;
        accept       = resolve_valid_i & resolve_is_cf_i & (resolve_epoch_i == epoch_q)
                       & (state_q == StIdle);
        mispredict   = accept & (exp_npc != resolve_pred_npc_i);
        // Exceptions are honoured in every state and win over a same-cycle mispredict.
        redirect_req = excp_valid_i | mispredict;
        redirect_tgt = excp_valid_i ? excp_target_i : exp_npc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            drain_cnt_q     <= 4'd0;
            epoch_q         <= 1'b0;
            update_taken_q  <= 1'b0;
            flush_q         <= 1'b0;
            update_target_q <= 32'd0;
            branch_cnt_q    <= '0;
            mispred_cnt_q   <= '0;
        end else begin
            update_taken_q <= 1'b0;
            flush_q        <= 1'b0;

            if (accept) begin
                branch_cnt_q <= branch_cnt_q + CNT_W'(1);
            end

            if (redirect_req) begin
                state_q         <= StRedirect;
                update_taken_q  <= 1'b1;
                flush_q         <= 1'b1;
                update_target_q <= redirect_tgt;
                epoch_q         <= ~epoch_q;
                drain_cnt_q     <= 4'd0;
                if (!excp_valid_i) begin
                    mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
                end
            end else begin
                unique case (state_q)
                    StIdle: begin
                        state_q <= StIdle;
                    end
                    StRedirect: begin
                        state_q     <= StDrain;
                        drain_cnt_q <= DrainLoad;
                    end
                    StDrain: begin
                        if (drain_cnt_q <= 4'd1) begin
                            state_q     <= StIdle;
                            drain_cnt_q <= 4'd0;
                        end else begin
                            drain_cnt_q <= drain_cnt_q - 4'd1;
                        end
                    end
                    default: begin
                        state_q     <= StIdle;
                        drain_cnt_q <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign epoch_o         = epoch_q;
    assign update_taken_o  = update_taken_q;
    assign update_target_o = update_target_q;
    assign flush_o         = flush_q;
    assign busy_o          = (state_q != StIdle);
    assign branch_cnt_o    = branch_cnt_q;
    assign mispred_cnt_o   = mispred_cnt_q;

endmodule

// File: tb/tb_bpu_update_gen.sv
// Directed bench for bpu_update_gen: expected outputs are queued per driven cycle and
// compared after the following clock edge.
module tb_bpu_update_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        resolve_valid_i;
    logic        resolve_is_cf_i;
    logic [31:0] resolve_pc_i;
    logic        resolve_taken_i;
    logic [31:0] resolve_target_i;
    logic [31:0] resolve_pred_npc_i;
    logic        resolve_epoch_i;
    logic        excp_valid_i;
    logic [31:0] excp_target_i;
    logic        epoch_o;
    logic        update_taken_o;
    logic [31:0] update_target_o;
    logic        flush_o;
    logic        busy_o;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispred_cnt_o;

    bpu_update_gen #(
        .DRAIN_CYCLES(2),
        .CNT_W       (32)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .resolve_valid_i   (resolve_valid_i),
        .resolve_is_cf_i   (resolve_is_cf_i),
        .resolve_pc_i      (resolve_pc_i),
        .resolve_taken_i   (resolve_taken_i),
        .resolve_target_i  (resolve_target_i),
        .resolve_pred_npc_i(resolve_pred_npc_i),
        .resolve_epoch_i   (resolve_epoch_i),
        .excp_valid_i      (excp_valid_i),
        .excp_target_i     (excp_target_i),
        .epoch_o           (epoch_o),
        .update_taken_o    (update_taken_o),
        .update_target_o   (update_target_o),
        .flush_o           (flush_o),
        .busy_o            (busy_o),
        .branch_cnt_o      (branch_cnt_o),
        .mispred_cnt_o     (mispred_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        taken;
        logic [31:0] target;
        logic        flush;
        logic        epoch;
        logic        busy;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Queue the outputs expected after the next clock edge.
    task automatic push(input string tag, input logic tk, input logic [31:0] tgt,
                        input logic ep, input logic bsy, input logic [31:0] bc,
                        input logic [31:0] mc);
        exp_t e;
        e.taken  = tk;
        e.target = tgt;
        e.flush  = tk;
        e.epoch  = ep;
        e.busy   = bsy;
        e.bc     = bc;
        e.mc     = mc;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic tick();
        exp_t  e;
        string t;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: observed empty queue, required an entry");
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk({t, ".taken"},  32'(update_taken_o), 32'(e.taken));
            chk({t, ".target"}, update_target_o,     e.target);
            chk({t, ".flush"},  32'(flush_o),        32'(e.flush));
            chk({t, ".epoch"},  32'(epoch_o),        32'(e.epoch));
            chk({t, ".busy"},   32'(busy_o),         32'(e.busy));
            chk({t, ".bcnt"},   branch_cnt_o,        e.bc);
            chk({t, ".mcnt"},   mispred_cnt_o,       e.mc);
        end
    endtask

    task automatic idle_in();
        resolve_valid_i    = 1'b0;
        resolve_is_cf_i    = 1'b0;
        resolve_pc_i       = 32'd0;
        resolve_taken_i    = 1'b0;
        resolve_target_i   = 32'd0;
        resolve_pred_npc_i = 32'd0;
        resolve_epoch_i    = 1'b0;
        excp_valid_i       = 1'b0;
        excp_target_i      = 32'd0;
    endtask

    task automatic resolve(input logic cf, input logic [31:0] pc, input logic tk,
                           input logic [31:0] tgt, input logic [31:0] pred, input logic ep);
        resolve_valid_i    = 1'b1;
        resolve_is_cf_i    = cf;
        resolve_pc_i       = pc;
        resolve_taken_i    = tk;
        resolve_target_i   = tgt;
        resolve_pred_npc_i = pred;
        resolve_epoch_i    = ep;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_in();
        rst = 1'b1;
        @(posedge clk);
        #1;
        push("reset", 0, 32'h0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            push("idle", 0, 32'h0, 0, 0, 0, 0);
            tick();
        end

        // Correct not-taken prediction.
        resolve(1, 32'h1c000004, 0, 32'h0, 32'h1c000008, 0);
        push("nt_ok", 0, 32'h0, 0, 0, 1, 0);
        tick();
        idle_in();
        push("nt_ok_hold", 0, 32'h0, 0, 0, 1, 0);
        tick();

        // Taken mispredict, then resolutions during REDIRECT/DRAIN are dropped.
        resolve(1, 32'h1c000010, 1, 32'h1c000100, 32'h1c000018, 0);
        push("tk_mis", 1, 32'h1c000100, 1, 1, 2, 1);
        tick();
        resolve(1, 32'h1c000020, 1, 32'h1c000200, 32'h1c000028, 1);
        push("drop_redir", 0, 32'h1c000100, 1, 1, 2, 1);
        tick();
        push("drop_drain1", 0, 32'h1c000100, 1, 1, 2, 1);
        tick();
        push("drop_drain2", 0, 32'h1c000100, 1, 0, 2, 1);
        tick();

        // Stale epoch, non-CF and invalid resolutions are ignored.
        resolve(1, 32'h1c000030, 1, 32'h1c000300, 32'h1c000038, 0);
        push("stale_epoch", 0, 32'h1c000100, 1, 0, 2, 1);
        tick();
        resolve(0, 32'h1c000030, 1, 32'h1c000300, 32'h1c000038, 1);
        push("non_cf", 0, 32'h1c000100, 1, 0, 2, 1);
        tick();
        resolve(1, 32'h1c000030, 1, 32'h1c000300, 32'h1c000038, 1);
        resolve_valid_i = 1'b0;
        push("not_valid", 0, 32'h1c000100, 1, 0, 2, 1);
        tick();

        // Correct taken prediction, and sequential npc wrapping at the top of memory.
        resolve(1, 32'h1c000200, 1, 32'h1c000300, 32'h1c000300, 1);
        push("tk_ok", 0, 32'h1c000100, 1, 0, 3, 1);
        tick();
        resolve(1, 32'hfffffffc, 0, 32'h0, 32'h00000000, 1);
        push("nt_wrap", 0, 32'h1c000100, 1, 0, 4, 1);
        tick();

        // Mispredict and exception together: exception target, no mispredict count.
        resolve(1, 32'h1c000400, 0, 32'h0, 32'h1c000500, 1);
        excp_valid_i  = 1'b1;
        excp_target_i = 32'h1c008000;
        push("excp_prio", 1, 32'h1c008000, 0, 1, 5, 1);
        tick();
        idle_in();
        push("excp_drain", 0, 32'h1c008000, 0, 1, 5, 1);
        tick();

        // Exception during DRAIN re-redirects and restarts the drain.
        excp_valid_i  = 1'b1;
        excp_target_i = 32'h1c00a000;
        push("excp_in_drain", 1, 32'h1c00a000, 1, 1, 5, 1);
        tick();
        idle_in();
        push("restart_d0", 0, 32'h1c00a000, 1, 1, 5, 1);
        tick();
        push("restart_d1", 0, 32'h1c00a000, 1, 1, 5, 1);
        tick();
        push("restart_d2", 0, 32'h1c00a000, 1, 0, 5, 1);
        tick();

        // Back-to-back exception pulses.
        excp_valid_i  = 1'b1;
        excp_target_i = 32'h1c00c000;
        push("b2b_first", 1, 32'h1c00c000, 0, 1, 5, 1);
        tick();
        excp_target_i = 32'h1c00e000;
        push("b2b_second", 1, 32'h1c00e000, 1, 1, 5, 1);
        tick();
        idle_in();
        push("b2b_drain", 0, 32'h1c00e000, 1, 1, 5, 1);
        tick();

        // Reset mid-DRAIN clears everything with no pulse afterwards.
        rst = 1'b1;
        push("rst_drain", 0, 32'h0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        push("post_rst", 0, 32'h0, 0, 0, 0, 0);
        tick();

        resolve(1, 32'h1c000010, 1, 32'h1c000100, 32'h1c000018, 0);
        push("post_rst_mis", 1, 32'h1c000100, 1, 1, 1, 1);
        tick();
        idle_in();
        push("post_rst_drain", 0, 32'h1c000100, 1, 1, 1, 1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
